// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store with one access in flight.
// Data normally wins; a saturating starve counter hands the port to fetch after MAX_WAIT losses.
module mem_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LATENCY  = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] CNT_LOAD   = 2'(LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] starve_q, starve_d;
    logic       owner_q, owner_d;   // 1 = data port owns the outstanding access
    logic       store_q, store_d;

    logic resp;
    logic can_grant;
    logic fetch_win;
    logic grant_f;
    logic grant_d;
    logic any_grant;

    // Grants are gated by reset so every output is 0 while reset is held.
    always_comb begin
        resp      = (state_q == BUSY) && (cnt_q == '0);
        can_grant = !reset && ((state_q == IDLE) || resp);
        fetch_win = if_req && (!d_req || (starve_q == STARVE_MAX));
        grant_f   = can_grant && fetch_win;
        grant_d   = can_grant && d_req && !fetch_win;
        any_grant = grant_f || grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            owner_q  <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            store_q  <= store_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        store_d  = store_q;

        case (state_q)
            IDLE:    if (any_grant) state_d = BUSY;
            BUSY:    if (resp && !any_grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (any_grant) begin
            cnt_d   = CNT_LOAD;
            owner_d = grant_d;
            store_d = grant_d && d_we;
        end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (!if_req || grant_f) begin
            starve_d = '0;
        end else if (grant_d && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        if_gnt    = grant_f;
        d_gnt     = grant_d;
        mem_req   = any_grant;
        mem_we    = grant_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_f) begin
            mem_addr = if_addr;
        end

        if_rvalid = resp && !owner_q;
        d_rvalid  = resp && owner_q;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !store_q) ? mem_rdata : '0;
    end

endmodule
